ifu_align: RTL and testbench

- Instruction aligner between the prefetch word stream and the ID stage.
- Accepts 32-bit word-aligned fetch words, handles 16-bit RVC instructions and 32-bit instructions that straddle word boundaries, and emits one aligned instruction per cycle with its PC and fault status.
- Output is registered, with a valid/ready handshake toward decode.

---
 rtl/ifu_align_pkg.sv | 30 +++
 rtl/ifu_align.sv | 182 ++++++++++++++++++
 tb/tb_ifu_align.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_align_pkg.sv
// ifu_align_pkg: shared types and helpers for the instruction aligner.
//   hold_t  - one held 16-bit instruction half (data, halfword PC, fault bits, valid)
//   is_rvc  - halfword length detection; also usable by decode
// Address/data widths default to 32 when the IM_* macros are not provided.
`ifndef IM_ADDR_LEN
`define IM_ADDR_LEN 32
`endif
`ifndef IM_DATA_LEN
`define IM_DATA_LEN 32
`endif

package ifu_align_pkg;

  localparam int IFU_ADDR_W = `IM_ADDR_LEN;
  localparam int IFU_DATA_W = `IM_DATA_LEN;

  typedef struct packed {
    logic [15:0]           data;
    logic [IFU_ADDR_W-1:0] pc;
    logic [1:0]            bad;
    logic                  valid;
  } hold_t;

  // A halfword starts a 16-bit instruction unless its low two bits are 11,
  // and only when the C extension is enabled.
  function automatic logic is_rvc(input logic c_ext, input logic [15:0] hw);
    return c_ext && (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/ifu_align.sv
// ifu_align: instruction aligner between the prefetch word stream and ID.
// Takes word-aligned 32-bit fetch words, splits/joins halves for RVC and
// word-straddling 32-bit instructions, and presents one instruction per
// cycle from a registered valid/ready output stage.
//
// Ports:
//   clk, rstn            clock; synchronous active-high reset (rstn=1 resets)
//   misa_c_ext           C extension enabled
//   flush, flush_pc      redirect: drop all held state, restart at flush_pc
//   in_valid/in_ready    fetch word handshake; in_pc, in_data, in_bad
//   out_valid/out_ready  decode handshake; out_pc, out_inst, out_rvc,
//                        out_bad, out_badaddr
//   perf_straddle,
//   perf_starve          saturating counters, present only with
//                        IFU_ALIGN_PERF_EN defined
//
// Build option: IFU_ALIGN_PERF_EN adds the two performance counters.
module ifu_align
  import ifu_align_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int DATA_W = IFU_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              misa_c_ext,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_bad,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic              out_rvc,
  output logic [1:0]        out_bad,
  output logic [ADDR_W-1:0] out_badaddr
`ifdef IFU_ALIGN_PERF_EN
  ,
  output logic [31:0]       perf_straddle,
  output logic [31:0]       perf_starve
`endif
);

  hold_t             h_q, h_d, up;
  logic [ADDR_W-1:0] exp_pc, exp_d;
  logic              skip, skip_d;
  logic              adv, stale, good, h_rvc, lo_rvc;
  logic [ADDR_W-1:0] h_word;

  logic              emit;
  logic [ADDR_W-1:0] e_pc, e_badaddr;
  logic [DATA_W-1:0] e_inst;
  logic              e_rvc;
  logic [1:0]        e_bad;

  assign adv    = ~out_valid | out_ready;
  // Words not at the expected address are leftovers from before a redirect.
  assign stale  = in_valid & (in_pc != exp_pc);
  assign good   = in_valid & ~stale;
  assign h_rvc  = is_rvc(misa_c_ext, h_q.data);
  assign lo_rvc = is_rvc(misa_c_ext, in_data[15:0]);
  assign h_word = h_q.pc & ~ADDR_W'(3);

  // Upper half of the incoming word as a hold entry.
  assign up = '{data: in_data[31:16], pc: in_pc + ADDR_W'(2), bad: in_bad, valid: 1'b1};

  // A held RVC drains before any new word is taken; stale words are always
  // swallowed so they never block the stream.
  assign in_ready = ~flush & (stale | (adv & ~(h_q.valid & h_rvc)));

  always_comb begin
    h_d       = h_q;
    exp_d     = exp_pc;
    skip_d    = skip;
    emit      = 1'b0;
    e_pc      = '0;
    e_inst    = '0;
    e_rvc     = 1'b0;
    e_bad     = '0;
    e_badaddr = '0;
    if (flush) begin
      h_d    = '0;
      exp_d  = flush_pc & ~ADDR_W'(3);
      skip_d = flush_pc[1];
      // Halfword target without C: hand ID a dummy so it can trap on the pc.
      if (!misa_c_ext && flush_pc[1]) begin
        emit = 1'b1;
        e_pc = flush_pc & ~ADDR_W'(1);
      end
    end else if (adv) begin
      if (h_q.valid && h_rvc) begin
        emit      = 1'b1;
        e_pc      = h_q.pc;
        e_inst    = {16'h0000, h_q.data};
        e_rvc     = 1'b1;
        e_bad     = h_q.bad;
        e_badaddr = (|h_q.bad) ? h_word : '0;
        h_d       = '0;
      end else if (good) begin
        exp_d = exp_pc + ADDR_W'(4);
        if (h_q.valid) begin
          // Straddle: held half is the low half of a 32-bit instruction.
          emit      = 1'b1;
          e_pc      = h_q.pc;
          e_inst    = {in_data[15:0], h_q.data};
          e_bad     = h_q.bad | in_bad;
          e_badaddr = (|h_q.bad) ? h_word : ((|in_bad) ? in_pc : '0);
          // A faulting word stops the stream; its upper half is not kept.
          h_d       = (|in_bad) ? '0 : up;
        end else if (skip) begin
          // Redirect landed mid-word: the low half is before the target.
          h_d    = up;
          skip_d = 1'b0;
        end else if (!lo_rvc) begin
          emit      = 1'b1;
          e_pc      = in_pc;
          e_inst    = in_data;
          e_bad     = in_bad;
          e_badaddr = (|in_bad) ? in_pc : '0;
        end else begin
          emit      = 1'b1;
          e_pc      = in_pc;
          e_inst    = {16'h0000, in_data[15:0]};
          e_rvc     = 1'b1;
          e_bad     = in_bad;
          e_badaddr = (|in_bad) ? in_pc : '0;
          h_d       = up;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      h_q         <= '0;
      exp_pc      <= '0;
      skip        <= 1'b0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_rvc     <= 1'b0;
      out_bad     <= '0;
      out_badaddr <= '0;
    end else begin
      h_q    <= h_d;
      exp_pc <= exp_d;
      skip   <= skip_d;
      if (flush || adv) begin
        out_valid <= emit;
        if (emit) begin
          out_pc      <= e_pc;
          out_inst    <= e_inst;
          out_rvc     <= e_rvc;
          out_bad     <= e_bad;
          out_badaddr <= e_badaddr;
        end
      end
    end
  end

`ifdef IFU_ALIGN_PERF_EN
  logic straddle;
  assign straddle = adv & ~flush & h_q.valid & ~h_rvc & good;

  always_ff @(posedge clk) begin
    if (rstn) begin
      perf_straddle <= '0;
      perf_starve   <= '0;
    end else begin
      if (straddle && perf_straddle != '1)
        perf_straddle <= perf_straddle + 32'd1;
      if (adv && !emit && !flush && perf_starve != '1)
        perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_align.sv
// tb_ifu_align: table-driven bench for ifu_align with an output scoreboard.
module tb_ifu_align;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rvc;
    logic [1:0]  bad;
    logic [31:0] badaddr;
  } exp_t;

  typedef struct {
    bit          fl;
    bit          c;
    logic [31:0] pc;
    logic [31:0] data;
    logic [1:0]  bad;
    int          n;
    exp_t        e0;
    exp_t        e1;
    bit          rdy0;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn, misa_c_ext, flush, in_valid, out_ready;
  logic [31:0] flush_pc, in_pc, in_data;
  logic [1:0]  in_bad;
  logic        in_ready, out_valid, out_rvc;
  logic [31:0] out_pc, out_inst, out_badaddr;
  logic [1:0]  out_bad;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  vec_t v[$];

  ifu_align dut (
    .clk(clk), .rstn(rstn), .misa_c_ext(misa_c_ext), .flush(flush),
    .flush_pc(flush_pc), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .in_bad(in_bad),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_rvc(out_rvc), .out_bad(out_bad),
    .out_badaddr(out_badaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard: every accepted output must match the oldest expectation.
  always @(negedge clk) begin
    if (!rstn && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual_pc=%h required=none", out_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", {out_pc, out_inst, out_rvc, out_bad, out_badaddr}, e);
      end
    end
  end

  function automatic exp_t E(input logic [31:0] pc, input logic [31:0] inst, input logic rvc,
                             input logic [1:0] bad, input logic [31:0] ba);
    exp_t x;
    x.pc = pc; x.inst = inst; x.rvc = rvc; x.bad = bad; x.badaddr = ba;
    return x;
  endfunction

  function automatic vec_t V(input bit fl, input bit c, input logic [31:0] pc,
                             input logic [31:0] data, input logic [1:0] bad, input int n,
                             input exp_t e0, input exp_t e1, input bit r0);
    vec_t x;
    x.fl = fl; x.c = c; x.pc = pc; x.data = data; x.bad = bad;
    x.n = n; x.e0 = e0; x.e1 = e1; x.rdy0 = r0;
    return x;
  endfunction

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_flush(input logic [31:0] p);
    flush_pc = p;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] d, input logic [1:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1; in_pc = p; in_data = d; in_bad = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout pc=%h actual=0 required=1", p);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    rstn = 1'b1; misa_c_ext = 1'b0; flush = 1'b0; flush_pc = '0;
    in_valid = 1'b0; in_pc = '0; in_data = '0; in_bad = '0; out_ready = 1'b1;

    // No C: plain 32-bit words, RVC-looking halves stay 32-bit, faulting word.
    v.push_back(V(1, 0, 32'h100, 0, 0, 0, z, z, 0));
    v.push_back(V(0, 0, 32'h100, 32'h00000013, 0, 1, E(32'h100, 32'h13, 0, 0, 0), z, 0));
    v.push_back(V(0, 0, 32'h104, 32'h00000013, 0, 1, E(32'h104, 32'h13, 0, 0, 0), z, 0));
    v.push_back(V(0, 0, 32'h108, 32'h00010001, 0, 1, E(32'h108, 32'h00010001, 0, 0, 0), z, 0));
    v.push_back(V(0, 0, 32'h10C, 32'h00000013, 2'b01, 1, E(32'h10C, 32'h13, 0, 2'b01, 32'h10C), z, 0));
    // C: RVC pair in one word; in_ready low while the upper half drains.
    v.push_back(V(1, 1, 32'h200, 0, 0, 0, z, z, 0));
    v.push_back(V(0, 1, 32'h200, 32'h00010001, 0, 2, E(32'h200, 1, 1, 0, 0), E(32'h202, 1, 1, 0, 0), 1));
    // Straddle; the second word's upper half 0x0000 is itself an RVC.
    v.push_back(V(1, 1, 32'h300, 0, 0, 0, z, z, 0));
    v.push_back(V(0, 1, 32'h300, 32'h00130001, 0, 1, E(32'h300, 1, 1, 0, 0), z, 0));
    v.push_back(V(0, 1, 32'h304, 32'h00000000, 0, 2, E(32'h302, 32'h13, 0, 0, 0), E(32'h306, 0, 1, 0, 0), 0));
    // Flush to halfword target, stale word dropped, lower half skipped.
    v.push_back(V(1, 1, 32'h402, 0, 0, 0, z, z, 0));
    v.push_back(V(0, 1, 32'h3F8, 32'hDEADBEEF, 0, 0, z, z, 0));
    v.push_back(V(0, 1, 32'h400, 32'h00010013, 0, 1, E(32'h402, 1, 1, 0, 0), z, 0));
    // Straddle whose second word faults.
    v.push_back(V(1, 1, 32'h500, 0, 0, 0, z, z, 0));
    v.push_back(V(0, 1, 32'h500, 32'h00130001, 0, 1, E(32'h500, 1, 1, 0, 0), z, 0));
    v.push_back(V(0, 1, 32'h504, 32'hFFFF0000, 2'b10, 1, E(32'h502, 32'h13, 0, 2'b10, 32'h504), z, 0));
    // No C, halfword redirect: dummy instruction at the target.
    v.push_back(V(1, 0, 32'h702, 0, 0, 1, E(32'h702, 0, 0, 0, 0), z, 0));

    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_bad", {out_rvc, out_bad, out_badaddr}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    foreach (v[i]) begin
      if (v[i].fl) begin
        drain();
        misa_c_ext = v[i].c;
        if (v[i].n > 0) q.push_back(v[i].e0);
        pulse_flush(v[i].pc);
      end else begin
        misa_c_ext = v[i].c;
        if (v[i].n > 0) q.push_back(v[i].e0);
        if (v[i].n > 1) q.push_back(v[i].e1);
        send(v[i].pc, v[i].data, v[i].bad);
      end
      if (v[i].rdy0) begin
        @(negedge clk);
        chk("in_ready_rvc_drain", in_ready, 0);
      end
    end

    // Backpressure: output holds, no word taken, no duplicate after release.
    drain();
    misa_c_ext = 1'b0;
    pulse_flush(32'h600);
    out_ready = 1'b0;
    q.push_back(E(32'h600, 32'h13, 0, 0, 0));
    send(32'h600, 32'h00000013, 0);
    in_valid = 1'b1; in_pc = 32'h604; in_data = 32'h00100093; in_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, out_pc, out_inst, in_ready}, {1'b1, 32'h600, 32'h13, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    q.push_back(E(32'h604, 32'h00100093, 0, 0, 0));
    send(32'h604, 32'h00100093, 0);

    // Reset with an output pending: it is lost, exp_pc restarts at 0.
    drain();
    misa_c_ext = 1'b1;
    pulse_flush(32'h800);
    out_ready = 1'b0;
    send(32'h800, 32'h00000013, 0);
    @(negedge clk);
    chk("pending_valid", out_valid, 1);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    q.push_back(E(32'h0, 32'h13, 0, 0, 0));
    send(32'h0, 32'h00000013, 0);
    drain();
    @(negedge clk);
    chk("end_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
